// File: rtl/inst_encoder_if.sv
`default_nettype none
// ============================================================================
// inst_encoder_if : field-bundle input and instruction output bus of inst_encoder
// Rev 1.0
// ============================================================================
interface inst_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              InValid;
  logic              InReady;
  logic [1:0]        InType;
  logic [4:0]        Rd;
  logic [4:0]        Rs1;
  logic [4:0]        Rs2;
  logic [2:0]        Funct3;
  logic [31:0]       ImmIn;
  logic              OutValid;
  logic              OutReady;
  logic [31:0]       InstCode;
  logic [ADDR_W-1:0] InstAddr;
  logic              ErrRange;
  logic              ErrType;
  logic              Wrapped;
  logic [15:0]       Count;

  modport master (
    output InValid, InType, Rd, Rs1, Rs2, Funct3, ImmIn, OutReady,
    input  InReady, OutValid, InstCode, InstAddr, ErrRange, ErrType, Wrapped, Count
  );

  modport slave (
    input  InValid, InType, Rd, Rs1, Rs2, Funct3, ImmIn, OutReady,
    output InReady, OutValid, InstCode, InstAddr, ErrRange, ErrType, Wrapped, Count
  );
endinterface
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// inst_encoder : packs RV32I load/addi/store fields into InstCode with a word address
// Rev 1.0
// ============================================================================
module inst_encoder #(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0
) (
  input  wire logic     clk,
  input  wire logic     reset,
  inst_encoder_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OUT  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] c_start_addr = ADDR_W'(START_ADDR);
  localparam logic [6:0]        c_op_load    = 7'b0000011;
  localparam logic [6:0]        c_op_addi    = 7'b0010011;
  localparam logic [6:0]        c_op_store   = 7'b0100011;

  state_t            state_q, state_d;
  logic [31:0]       code_q, code_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  logic              wrapped_q, wrapped_d;
  logic              err_range_q, err_range_d;
  logic              err_type_q, err_type_d;

  logic [31:0]       w_enc;
  logic              w_imm_ok;

  // A 12-bit signed immediate means bits 31..11 are all copies of the sign.
  assign w_imm_ok = (&bus.ImmIn[31:11]) | ~(|bus.ImmIn[31:11]);

  always_comb begin
    w_enc = {bus.ImmIn[11:0], bus.Rs1, bus.Funct3, bus.Rd, c_op_addi};
    case (bus.InType)
      2'b00:   w_enc = {bus.ImmIn[11:0], bus.Rs1, bus.Funct3, bus.Rd, c_op_load};
      2'b10:   w_enc = {bus.ImmIn[11:5], bus.Rs2, bus.Rs1, bus.Funct3, bus.ImmIn[4:0], c_op_store};
      default: w_enc = {bus.ImmIn[11:0], bus.Rs1, bus.Funct3, bus.Rd, c_op_addi};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    addr_d      = addr_q;
    count_d     = count_q;
    wrapped_d   = wrapped_q;
    err_range_d = 1'b0;
    err_type_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.InValid) begin
          if (bus.InType == 2'b11) begin
            err_type_d = 1'b1;
          end else if (!w_imm_ok) begin
            err_range_d = 1'b1;
          end else begin
            code_d  = w_enc;
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (bus.OutReady) begin
          state_d = IDLE;
          addr_d  = addr_q + ADDR_W'(1);
          if (&addr_q) begin
            wrapped_d = 1'b1;
          end
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      code_q      <= '0;
      addr_q      <= c_start_addr;
      count_q     <= '0;
      wrapped_q   <= 1'b0;
      err_range_q <= 1'b0;
      err_type_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      wrapped_q   <= wrapped_d;
      err_range_q <= err_range_d;
      err_type_q  <= err_type_d;
    end
  end

  assign bus.InReady  = (state_q == IDLE);
  assign bus.OutValid = (state_q == OUT);
  assign bus.InstCode = code_q;
  assign bus.InstAddr = addr_q;
  assign bus.ErrRange = err_range_q;
  assign bus.ErrType  = err_type_q;
  assign bus.Wrapped  = wrapped_q;
  assign bus.Count    = count_q;

endmodule
`default_nettype wire
